aud_recorder_stream: RTL

//  Parametrised I2S capture engine: deserialises codec ADCDAT on the bit clock, frames samples on
//  LRC, and writes them to external SRAM with a one-cycle write strobe. Adds left/right/stereo modes,

---
 rtl/aud_pkg.sv | 37 +++
 rtl/i2s_deserializer.sv | 63 ++++++
 rtl/aud_recorder_stream.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S recorder: FSM state encoding,
// channel-mode codes, default widths, and small decode helpers.
package aud_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 20;

  localparam logic [1:0] MODE_LEFT   = 2'd0;
  localparam logic [1:0] MODE_RIGHT  = 2'd1;
  localparam logic [1:0] MODE_STEREO = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_WRITE = 3'd3,
    S_PAUSE = 3'd4
  } rec_state_e;

  // The reserved mode code behaves exactly like left-only.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    case (mode)
      MODE_RIGHT:  return MODE_RIGHT;
      MODE_STEREO: return MODE_STEREO;
      default:     return MODE_LEFT;
    endcase
  endfunction

  // States in which the recorder reports itself busy.
  function automatic logic is_busy(input rec_state_e st);
    case (st)
      S_WAIT, S_SHIFT, S_WRITE: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2s_deserializer.sv
// I2S slot deserialiser: detects LRC edges, skips the bit that shares the
// edge cycle, then shifts DATA_W bits MSB first. o_done pulses one cycle
// after the last bit lands; o_abort flags an LRC edge that cuts a slot short.
// Bits past DATA_W in a slot are ignored until the next edge re-arms it.
module i2s_deserializer
  import aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic              o_edge,
  output logic              o_abort,
  output logic              o_done,
  output logic [DATA_W-1:0] o_sample
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic              lrc_r;
  logic              active_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              done_r;
  logic              edge_s;

  assign edge_s   = i_lrc ^ lrc_r;
  assign o_edge   = edge_s;
  assign o_abort  = edge_s & active_r;
  assign o_done   = done_r;
  assign o_sample = shift_r;

  // Edge history, slot bit counter and MSB-first shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_r    <= 1'b0;
      active_r <= 1'b0;
      cnt_r    <= '0;
      shift_r  <= '0;
      done_r   <= 1'b0;
    end else begin
      lrc_r  <= i_lrc;
      done_r <= 1'b0;
      if (edge_s) begin
        cnt_r    <= '0;
        active_r <= 1'b1;
      end else if (active_r) begin
        shift_r <= {shift_r[DATA_W-2:0], i_data};
        if (cnt_r == LAST_CNT) begin
          active_r <= 1'b0;
          done_r   <= 1'b1;
          cnt_r    <= '0;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/aud_recorder_stream.sv
// I2S capture engine: frames codec samples by LRC slot, writes them to SRAM
// with a one-cycle strobe, and tracks the recorded length and full state.
// Supports left/right/stereo capture, pause/resume and stop with deferred
// clearing of address/length on the next start.
module aud_recorder_stream
  import aud_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_we,
  output logic [ADDR_W:0]   o_len,
  output logic              o_full,
  output logic              o_busy
);

  // Length value just before the final write that fills the SRAM.
  localparam logic [ADDR_W:0] LAST_LEN = {1'b0, {ADDR_W{1'b1}}};

  rec_state_e        state_r;
  rec_state_e        state_n;
  logic [1:0]        mode_r;
  logic              want_right_r;
  logic              slot_r;
  logic              clear_pending_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   len_r;
  logic [DATA_W-1:0] data_r;
  logic              we_r;
  logic              full_r;
  logic              busy_r;

  logic              edge_s;
  logic              abort_s;
  logic              done_s;
  logic [DATA_W-1:0] sample_s;
  logic              want_lrc_s;
  logic              wanted_s;
  logic              start_ok_s;
  logic              will_full_s;
  logic              write_s;
  logic              busy_n_s;
  logic              leave_s;
  logic              enter_shift_s;

  i2s_deserializer #(
    .DATA_W (DATA_W)
  ) u_deser (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_lrc    (i_lrc),
    .i_data   (i_data),
    .o_edge   (edge_s),
    .o_abort  (abort_s),
    .o_done   (done_s),
    .o_sample (sample_s)
  );

  // Slot polarity that opens the next sample we want; stereo alternates L then R.
  always_comb begin
    want_lrc_s = 1'b0;
    case (mode_r)
      MODE_RIGHT:  want_lrc_s = 1'b1;
      MODE_STEREO: want_lrc_s = want_right_r;
      default:     want_lrc_s = 1'b0;
    endcase
    wanted_s    = edge_s & (i_lrc == want_lrc_s);
    start_ok_s  = i_start & (~full_r | clear_pending_r);
    will_full_s = (len_r == LAST_LEN);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; stop beats pause beats start in every state.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_stop || i_pause) begin
          state_n = S_IDLE;
        end else if (start_ok_s) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (i_pause) begin
          state_n = S_PAUSE;
        end else if (wanted_s) begin
          state_n = S_SHIFT;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_SHIFT: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (i_pause) begin
          state_n = S_PAUSE;
        end else if (done_s) begin
          state_n = S_WRITE;
        end else if (abort_s) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_SHIFT;
        end
      end
      S_WRITE: begin
        if (i_stop || will_full_s) begin
          state_n = S_IDLE;
        end else if (i_pause) begin
          state_n = S_PAUSE;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (i_pause) begin
          state_n = S_PAUSE;
        end else if (i_start) begin
          state_n = S_WAIT;
        end else begin
          state_n = S_PAUSE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output/transition decode feeding the registered datapath.
  always_comb begin
    write_s       = (state_r == S_WRITE);
    busy_n_s      = is_busy(state_n);
    leave_s       = ((state_r == S_IDLE) || (state_r == S_PAUSE)) && (state_n == S_WAIT);
    enter_shift_s = (state_r == S_WAIT) && (state_n == S_SHIFT);
  end

  // Registered outputs, address/length counters, mode latch and clear handling.
  // The write strobe follows the S_WRITE cycle, so a stop or pause seen in
  // that cycle still lets the write complete.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_r            <= 1'b0;
      busy_r          <= 1'b0;
      data_r          <= '0;
      addr_r          <= '0;
      len_r           <= '0;
      full_r          <= 1'b0;
      clear_pending_r <= 1'b0;
      mode_r          <= MODE_LEFT;
      want_right_r    <= 1'b0;
      slot_r          <= 1'b0;
    end else begin
      we_r   <= write_s;
      busy_r <= busy_n_s;
      if (write_s) begin
        data_r       <= sample_s;
        want_right_r <= (mode_r == MODE_STEREO) && !slot_r;
        if (will_full_s) begin
          full_r <= 1'b1;
        end
      end
      // Advance after the strobe; the address parks on the last word when full.
      if (we_r) begin
        len_r <= len_r + (ADDR_W + 1)'(1);
        if (len_r != LAST_LEN) begin
          addr_r <= addr_r + ADDR_W'(1);
        end
      end
      if (i_stop) begin
        clear_pending_r <= 1'b1;
      end
      if (enter_shift_s) begin
        slot_r <= i_lrc;
      end
      if (leave_s) begin
        mode_r       <= norm_mode(i_mode);
        want_right_r <= 1'b0;
        if ((state_r == S_IDLE) && clear_pending_r) begin
          addr_r          <= '0;
          len_r           <= '0;
          full_r          <= 1'b0;
          clear_pending_r <= 1'b0;
        end
      end
    end
  end

  assign o_we      = we_r;
  assign o_busy    = busy_r;
  assign o_data    = data_r;
  assign o_address = addr_r;
  assign o_len     = len_r;
  assign o_full    = full_r;

endmodule
